delay_line_seq: RTL and testbench

Stream sequencer for a ce-gated delay line of depth DELAY in the SGM pixel pipeline. It converts a valid/ready pixel stream with end-of-line markers into a delay-line clock-enable. It suppresses the DELAY-1 priming outputs at line start and injects DELAY-1 pad samples at line end to drain the line. The result is that each input line yields exactly the same number of aligned output pixels.

---
 rtl/sgm_pkg.sv | 17 +
 rtl/delay_line_seq.sv | 88 ++++++++
 tb/tb_delay_line_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sgm_pkg.sv
// sgm_pkg: shared state encoding and helpers for the SGM pixel pipeline
package sgm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/delay_line_seq.sv
// delay_line_seq: turns a valid/ready pixel stream into a delay-line clock enable,
// hiding the priming samples at line start and draining each line with pads
module delay_line_seq
    import sgm_pkg::*;
#(
    parameter int          N     = 8,
    parameter int          DELAY = 5,
    parameter logic [N-1:0] PAD  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    input  logic         s_last,
    output logic         dl_ce,
    output logic [N-1:0] dl_idata,
    input  logic [N-1:0] dl_odata,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         m_last
);

    localparam int            CW      = clog2(DELAY + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);
    localparam logic [CW-1:0] PAD_MAX = CW'((DELAY > 1) ? DELAY - 2 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, dcnt_q;
    logic          valid_q, last_q;
    logic          free, fire, emit, drain_end, line_end;

    assign free      = !valid_q || m_ready;
    assign fire      = rst_n && free && (state_q == ST_DRAIN || s_valid);
    assign emit      = fire && cnt_q == CNT_MAX;
    assign drain_end = state_q == ST_DRAIN && dcnt_q == PAD_MAX;
    assign line_end  = (DELAY > 1) ? drain_end : s_last;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_FILL;
        else        state_q <= state_d;

    // Next state: every transition is tied to a delay-line clock enable
    always_comb begin
        state_d = state_q;
        if (fire)
            state_d = (DELAY == 1)          ? ST_RUN :
                      (state_q == ST_DRAIN) ? (drain_end ? ST_FILL : ST_DRAIN) :
                      s_last                ? ST_DRAIN :
                      (cnt_q >= PAD_MAX)    ? ST_RUN : state_q;
    end

    // Line counters: saturating ce count since line start, pad count while draining
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q  <= '0;
            dcnt_q <= '0;
        end else if (fire) begin
            cnt_q  <= drain_end ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            dcnt_q <= (state_q == ST_DRAIN && !drain_end) ? dcnt_q + 1'b1 : '0;
        end

    // Output qualifiers: loaded on each ce edge, dropped once downstream takes them
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (fire) begin
            valid_q <= emit;
            last_q  <= emit && line_end;
        end else if (m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end

    // Stream and delay-line side outputs; handshakes are held off during reset
    always_comb begin
        s_ready  = rst_n && free && state_q != ST_DRAIN;
        dl_ce    = fire;
        dl_idata = (state_q == ST_DRAIN) ? PAD : s_data;
        m_valid  = valid_q;
        m_last   = last_q;
        m_data   = dl_odata;
    end

endmodule

// File: tb/tb_delay_line_seq.sv
// tb_delay_line_seq: directed scoreboard bench for delay_line_seq at DELAY=3 and DELAY=1
module tb_delay_line_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b1;
    logic [N-1:0] s_data = '0;
    logic         sel = 1'b0;

    logic         sr3, ce3, mv3, ml3, sr1, ce1, mv1, ml1;
    logic [N-1:0] di3, do3, md3, di1, do1, md1;
    logic [N-1:0] dl3 [3];
    logic [N-1:0] dl1;

    logic         sr, ce, mv, ml;
    logic [N-1:0] md;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           ce_cnt = 0;
    int           srlo_cnt = 0;
    int           out_cnt = 0;
    int           acc_at [256];
    int           out_at [256];
    logic [N:0]   q [$];
    logic [N-1:0] bp_val = '0;
    logic         acc = 1'b0;

    always #5 clk = ~clk;

    delay_line_seq #(.N(N), .DELAY(3), .PAD(8'h00)) u3 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr3), .s_data(s_data),
        .s_last(s_last), .dl_ce(ce3), .dl_idata(di3), .dl_odata(do3), .m_valid(mv3),
        .m_ready(m_ready), .m_data(md3), .m_last(ml3)
    );

    delay_line_seq #(.N(N), .DELAY(1), .PAD(8'h00)) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr1), .s_data(s_data),
        .s_last(s_last), .dl_ce(ce1), .dl_idata(di1), .dl_odata(do1), .m_valid(mv1),
        .m_ready(m_ready), .m_data(md1), .m_last(ml1)
    );

    // Behavioural delay lines: no reset, so stale contents survive across lines
    always_ff @(posedge clk)
        if (ce3) begin
            dl3[0] <= di3;
            dl3[1] <= dl3[0];
            dl3[2] <= dl3[1];
        end
    assign do3 = dl3[2];

    always_ff @(posedge clk)
        if (ce1) dl1 <= di1;
    assign do1 = dl1;

    assign sr = sel ? sr1 : sr3;
    assign ce = sel ? ce1 : ce3;
    assign mv = sel ? mv1 : mv3;
    assign ml = sel ? ml1 : ml3;
    assign md = sel ? md1 : md3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ce_cnt = 0;
        srlo_cnt = 0;
        out_cnt = 0;
        foreach (acc_at[i]) begin
            acc_at[i] = 0;
            out_at[i] = 0;
        end
    endtask

    task automatic observe();
        logic [N:0] e;
        cyc++;
        if (ce) ce_cnt++;
        if (!sr) srlo_cnt++;
        if (mv && m_ready) begin
            if (sel) chk("lat1_depth", q.size(), 1);
            chk("out_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data_last", {ml, md}, e);
            end
            out_cnt++;
            out_at[md] = cyc;
        end
        acc = s_valid && sr;
        if (acc) begin
            q.push_back({s_last, s_data});
            acc_at[s_data] = cyc;
        end
    endtask

    task automatic tick();
        logic [N-1:0] t;
        @(negedge clk);
        if (bp_val != 0 && mv && md == bp_val) begin
            t = bp_val;
            bp_val = '0;
            m_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk("bp_ce", ce, 0);
                chk("bp_hold", md, t);
                chk("bp_sready", sr, 0);
                chk("bp_valid", mv, 1);
                @(negedge clk);
            end
            m_ready = 1'b1;
        end
        #1;
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_line(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            s_valid = 1'b1;
            s_data = N'(first + i);
            s_last = (i == n - 1);
            k = 0;
            acc = 1'b0;
            while (!acc && k < 50) begin
                tick();
                k++;
            end
            chk("accept_timeout", acc, 1);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds handshakes low even with a pixel offered
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce", ce, 0);
        chk("rst_sready", sr, 0);
        chk("rst_mvalid", mv, 0);
        chk("rst_mlast", ml, 0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        chk("idle_sready", sr, 1);

        // Line 1..5: 7 ce pulses, two drain cycles, outputs back to back
        clr();
        send_line(1, 5);
        idle(6);
        chk("t1_ce", ce_cnt, 7);
        chk("t1_srlo", srlo_cnt, 2);
        chk("t1_outs", out_cnt, 5);
        chk("t1_consec", out_at[5] - out_at[1], 4);
        chk("t1_lat", out_at[1] - acc_at[1], 3);
        chk("t1_sb", q.size(), 0);

        // Single-pixel line shorter than the delay
        clr();
        send_line(9, 1);
        idle(5);
        chk("t2_ce", ce_cnt, 3);
        chk("t2_outs", out_cnt, 1);
        chk("t2_sb", q.size(), 0);

        // Backpressure while output 2 is presented
        clr();
        bp_val = 8'd2;
        send_line(1, 6);
        idle(8);
        chk("t3_bp_seen", bp_val, 0);
        chk("t3_ce", ce_cnt, 8);
        chk("t3_outs", out_cnt, 6);
        chk("t3_sb", q.size(), 0);

        // Back-to-back lines with s_valid held high across the boundary
        clr();
        send_line(10, 4);
        send_line(20, 4);
        idle(6);
        chk("t4_ce", ce_cnt, 12);
        chk("t4_outs", out_cnt, 8);
        chk("t4_gap", acc_at[20] - acc_at[13], 3);
        chk("t4_sb", q.size(), 0);

        // Reset during the final drain cycle, then a fresh line
        clr();
        send_line(1, 4);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_mvalid", mv, 0);
        chk("t5_ce", ce, 0);
        chk("t5_sready", sr, 0);
        q.delete();
        idle(2);
        rst_n = 1'b1;
        clr();
        send_line(7, 3);
        idle(6);
        chk("t5_outs", out_cnt, 3);
        chk("t5_ce_line", ce_cnt, 5);
        chk("t5_sb", q.size(), 0);

        // DELAY=1 instance: one-cycle latency, never stalls upstream
        rst_n = 1'b0;
        sel = 1'b1;
        q.delete();
        idle(2);
        rst_n = 1'b1;
        clr();
        send_line(1, 3);
        idle(3);
        chk("t6_srlo", srlo_cnt, 0);
        chk("t6_ce", ce_cnt, 3);
        chk("t6_outs", out_cnt, 3);
        chk("t6_lat", out_at[1] - acc_at[1], 1);
        chk("t6_consec", out_at[3] - out_at[1], 2);
        chk("t6_sb", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
